// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants, state encoding and axis step helper
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int BALL_R = 10;

    localparam logic [9:0] X_MIN         = 10'(BALL_R);
    localparam logic [9:0] X_MAX         = 10'(H_RES - BALL_R);
    localparam logic [9:0] Y_MIN         = 10'(BALL_R);
    localparam logic [9:0] Y_MAX_DEFAULT = 10'(V_RES - BALL_R);

    localparam int CRASH_LEFT  = 3;
    localparam int CRASH_RIGHT = 2;
    localparam int CRASH_UP    = 1;
    localparam int CRASH_DOWN  = 0;

    localparam logic [1:0] DIR_INIT = 2'b10;

    // One-pixel move toward inc, saturating at [lo,hi] so the 10-bit value never wraps.
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                             input logic [9:0] lo, input logic [9:0] hi);
        if (inc)
            return (pos >= hi) ? hi : pos + 10'd1;
        else
            return (pos <= lo) ? lo : pos - 10'd1;
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - frame/crash/control inputs and ball state outputs of ball_motion
interface ball_motion_if;
    logic       iFrame_tick;
    logic [3:0] iCrash;
    logic       iStart;
    logic       iPause;
    logic [9:0] oBall_x;
    logic [9:0] oBall_y;
    logic [1:0] oDir;
    logic [1:0] oLives;
    logic [1:0] oState;
    logic       oBounce;
    logic       oMiss;

    modport master (
        output iFrame_tick, iCrash, iStart, iPause,
        input  oBall_x, oBall_y, oDir, oLives, oState, oBounce, oMiss
    );

    modport slave (
        input  iFrame_tick, iCrash, iStart, iPause,
        output oBall_x, oBall_y, oDir, oLives, oState, oBounce, oMiss
    );
endinterface

// File: rtl/ball_motion_tick_divider.sv
// rtl/ball_motion_tick_divider.sv - frame tick divider producing the one-pixel step enable
module tick_divider #(
    parameter int SPEED_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_tick,
    input  logic i_pause,
    output logic o_step
);
    logic [3:0] r_div;
    logic       w_at_end;
    logic       w_count;

    assign w_at_end = (r_div == 4'(SPEED_DIV - 1));
    assign w_count  = i_en & i_tick & ~i_pause;
    assign o_step   = w_count & w_at_end;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_div <= '0;
        else if (i_clr)
            r_div <= '0;
        else if (w_count)
            r_div <= w_at_end ? 4'd0 : r_div + 4'd1;
    end
endmodule

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - ball trajectory, reflection, miss detection and serve/miss/game-over sequencing
import game_pkg::*;

module ball_motion #(
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int Y_MAX       = 470,
    parameter int SPEED_DIV   = 1,
    parameter int HOLD_FRAMES = 60,
    parameter int LIVES       = 3
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    ball_motion_if.slave  bus
);
    localparam logic [9:0] X_INIT_V = 10'(X_INIT);
    localparam logic [9:0] Y_INIT_V = 10'(Y_INIT);
    localparam logic [9:0] Y_MISS_V = 10'(Y_MAX);
    localparam logic [1:0] LIVES_V  = 2'(LIVES);
    localparam logic [7:0] HOLD_END = 8'(HOLD_FRAMES - 1);

    state_t     r_state, w_state;
    logic [9:0] r_x, w_x, r_y, w_y;
    logic [1:0] r_dir, w_dir, r_lives, w_lives;
    logic [7:0] r_hold, w_hold;
    logic       r_bounce, w_bounce, r_miss, w_miss;

    logic       w_step, w_div_clr;
    logic       w_left, w_right, w_up, w_down;
    logic       w_dx, w_dy, w_hit_miss;
    logic [9:0] w_nx, w_ny;

    tick_divider #(.SPEED_DIV(SPEED_DIV)) u_div (
        .i_clk   (iCLK),
        .i_rst_n (iRST_N),
        .i_en    (r_state == RUN),
        .i_clr   (w_div_clr),
        .i_tick  (bus.iFrame_tick),
        .i_pause (bus.iPause),
        .o_step  (w_step)
    );

    assign w_left  = bus.iCrash[CRASH_LEFT];
    assign w_right = bus.iCrash[CRASH_RIGHT];
    assign w_up    = bus.iCrash[CRASH_UP];
    assign w_down  = bus.iCrash[CRASH_DOWN];

    assign w_hit_miss = w_down && (r_y >= Y_MISS_V);

    // Direction resolves first, so a wall hit moves the ball away from the wall on the same step.
    assign w_dx = (w_left && !w_right) ? 1'b1 : (w_right && !w_left) ? 1'b0 : r_dir[1];
    assign w_dy = (w_up && !w_down)    ? 1'b1 : (w_down && !w_up)    ? 1'b0 : r_dir[0];
    assign w_nx = (w_left && w_right) ? r_x : step_axis(r_x, w_dx, X_MIN, X_MAX);
    assign w_ny = (w_up && w_down)    ? r_y : step_axis(r_y, w_dy, Y_MIN, Y_MAX_DEFAULT);

    always_comb begin
        w_state   = r_state;
        w_x       = r_x;
        w_y       = r_y;
        w_dir     = r_dir;
        w_lives   = r_lives;
        w_hold    = r_hold;
        w_bounce  = 1'b0;
        w_miss    = 1'b0;
        w_div_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.iStart) begin
                    w_state   = RUN;
                    w_div_clr = 1'b1;
                end
            end
            RUN: begin
                if (w_step) begin
                    if (w_hit_miss) begin
                        w_lives = r_lives - 2'd1;
                        w_miss  = 1'b1;
                        w_hold  = '0;
                        w_state = (r_lives == 2'd1) ? OVER : MISS;
                    end else begin
                        w_x      = w_nx;
                        w_y      = w_ny;
                        w_dir    = {w_dx, w_dy};
                        w_bounce = ({w_dx, w_dy} != r_dir);
                    end
                end
            end
            MISS: begin
                if (bus.iFrame_tick) begin
                    if (r_hold == HOLD_END) begin
                        w_hold  = '0;
                        w_x     = X_INIT_V;
                        w_y     = Y_INIT_V;
                        w_dir   = DIR_INIT;
                        w_state = IDLE;
                    end else begin
                        w_hold = r_hold + 8'd1;
                    end
                end
            end
            OVER: begin
                if (bus.iStart) begin
                    w_lives = LIVES_V;
                    w_x     = X_INIT_V;
                    w_y     = Y_INIT_V;
                    w_dir   = DIR_INIT;
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state  <= IDLE;
            r_x      <= X_INIT_V;
            r_y      <= Y_INIT_V;
            r_dir    <= DIR_INIT;
            r_lives  <= LIVES_V;
            r_hold   <= '0;
            r_bounce <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_x      <= w_x;
            r_y      <= w_y;
            r_dir    <= w_dir;
            r_lives  <= w_lives;
            r_hold   <= w_hold;
            r_bounce <= w_bounce;
            r_miss   <= w_miss;
        end
    end

    assign bus.oBall_x = r_x;
    assign bus.oBall_y = r_y;
    assign bus.oDir    = r_dir;
    assign bus.oLives  = r_lives;
    assign bus.oState  = r_state;
    assign bus.oBounce = r_bounce;
    assign bus.oMiss   = r_miss;
endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - self-checking bench for ball_motion
module tb_ball_motion;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_motion_if bif ();
    ball_motion_if bif2 ();

    ball_motion dut (.iCLK(clk), .iRST_N(rst_n), .bus(bif));
    ball_motion #(.SPEED_DIV(2)) dut2 (.iCLK(clk), .iRST_N(rst_n), .bus(bif2));

    typedef struct {
        int x, y, dir, lives, state, bounce, miss;
    } exp_t;

    typedef struct {
        logic       start, tick, pause;
        logic [3:0] crash;
        int         x, y, dir, state, bounce;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_x, m_y, m_dir, m_lives, m_state, m_hold, m_bounce, m_miss;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".x"},      int'(bif.oBall_x), e.x);
        chk({tag, ".y"},      int'(bif.oBall_y), e.y);
        chk({tag, ".dir"},    int'(bif.oDir),    e.dir);
        chk({tag, ".lives"},  int'(bif.oLives),  e.lives);
        chk({tag, ".state"},  int'(bif.oState),  e.state);
        chk({tag, ".bounce"}, int'(bif.oBounce), e.bounce);
        chk({tag, ".miss"},   int'(bif.oMiss),   e.miss);
    endtask

    task automatic model_reset();
        m_x = 320; m_y = 240; m_dir = 2; m_lives = 3; m_state = 0; m_hold = 0;
        m_bounce = 0; m_miss = 0;
    endtask

    task automatic push_model();
        exp_t e;
        e.x = m_x; e.y = m_y; e.dir = m_dir; e.lives = m_lives; e.state = m_state;
        e.bounce = m_bounce; e.miss = m_miss;
        sb_q.push_back(e);
    endtask

    // Reference behaviour for SPEED_DIV=1, HOLD_FRAMES=60, LIVES=3.
    task automatic model_step(input logic start, input logic tick, input logic pause,
                              input logic [3:0] c);
        int dx, dy;
        m_bounce = 0;
        m_miss = 0;
        case (m_state)
            0: if (start) m_state = 1;
            1: if (tick && !pause) begin
                if (c[0] && m_y >= 470) begin
                    m_miss = 1;
                    m_state = (m_lives == 1) ? 3 : 2;
                    m_lives = m_lives - 1;
                    m_hold = 0;
                end else begin
                    dx = m_dir / 2;
                    dy = m_dir % 2;
                    if (c[3] && !c[2]) dx = 1;
                    if (c[2] && !c[3]) dx = 0;
                    if (c[1] && !c[0]) dy = 1;
                    if (c[0] && !c[1]) dy = 0;
                    if (!(c[3] && c[2])) m_x = dx ? ((m_x >= 630) ? 630 : m_x + 1)
                                                  : ((m_x <= 10) ? 10 : m_x - 1);
                    if (!(c[1] && c[0])) m_y = dy ? ((m_y >= 470) ? 470 : m_y + 1)
                                                  : ((m_y <= 10) ? 10 : m_y - 1);
                    if (dx * 2 + dy != m_dir) m_bounce = 1;
                    m_dir = dx * 2 + dy;
                end
            end
            2: if (tick) begin
                m_hold++;
                if (m_hold == 60) begin
                    m_hold = 0; m_x = 320; m_y = 240; m_dir = 2; m_state = 0;
                end
            end
            default: if (start) begin
                m_lives = 3; m_x = 320; m_y = 240; m_dir = 2; m_state = 0;
            end
        endcase
        push_model();
    endtask

    task automatic drive(input logic start, input logic tick, input logic pause,
                         input logic [3:0] c);
        bif.iStart = start; bif.iFrame_tick = tick; bif.iPause = pause; bif.iCrash = c;
    endtask

    task automatic cyc(input logic start, input logic tick, input logic pause,
                       input logic [3:0] c, input string tag);
        drive(start, tick, pause, c);
        model_step(start, tick, pause, c);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic run_to_y(input int target, input string tag);
        for (int i = 0; i < 600 && m_y != target; i++) cyc(1'b0, 1'b1, 1'b0, 4'b0000, tag);
        chk({tag, ".reached_y"}, int'(bif.oBall_y), target);
    endtask

    task automatic d2(input logic start, input logic tick, input logic pause,
                      input int ex, input int ey, input string tag);
        bif2.iStart = start; bif2.iFrame_tick = tick; bif2.iPause = pause; bif2.iCrash = 4'b0;
        @(posedge clk);
        #1;
        chk({tag, ".x"}, int'(bif2.oBall_x), ex);
        chk({tag, ".y"}, int'(bif2.oBall_y), ey);
    endtask

    vec_t tv[12];

    initial begin
        tv[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 320, 240, 2, 1, 0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 321, 239, 2, 1, 0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 322, 238, 2, 1, 0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 322, 238, 2, 1, 0};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 4'b0010, 323, 239, 3, 1, 1};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 323, 239, 3, 1, 0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 4'b1000, 324, 240, 3, 1, 0};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 4'b0100, 323, 241, 1, 1, 1};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 4'b1100, 323, 242, 1, 1, 0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 4'b0011, 322, 242, 1, 1, 0};
        tv[10] = '{1'b0, 1'b1, 1'b0, 4'b0001, 321, 241, 0, 1, 1};
        tv[11] = '{1'b1, 1'b1, 1'b0, 4'b0000, 320, 240, 0, 1, 0};

        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        bif2.iStart = 1'b0; bif2.iFrame_tick = 1'b0; bif2.iPause = 1'b0; bif2.iCrash = 4'b0;
        model_reset();
        push_model();
        repeat (2) @(posedge clk);
        #1;
        compare_out("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 4'b0000, "idle");

        for (int i = 0; i < 12; i++) begin
            exp_t e;
            drive(tv[i].start, tv[i].tick, tv[i].pause, tv[i].crash);
            e.x = tv[i].x; e.y = tv[i].y; e.dir = tv[i].dir; e.lives = 3;
            e.state = tv[i].state; e.bounce = tv[i].bounce; e.miss = 0;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            compare_out($sformatf("vec%0d", i));
        end

        #3;
        rst_n = 1'b0;
        model_reset();
        push_model();
        #1;
        compare_out("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(1'b1, 1'b0, 1'b0, 4'b0000, "serve");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 4'b0000, "free");
        chk("free.x_final", int'(bif.oBall_x), 325);
        chk("free.y_final", int'(bif.oBall_y), 235);

        run_to_y(11, "to_top");
        cyc(1'b0, 1'b1, 1'b0, 4'b0010, "top_bounce");
        chk("top_bounce.y", int'(bif.oBall_y), 12);
        chk("top_bounce.pulse", int'(bif.oBounce), 1);
        cyc(1'b0, 1'b0, 1'b0, 4'b0000, "bounce_end");
        chk("bounce_end.pulse", int'(bif.oBounce), 0);
        cyc(1'b0, 1'b1, 1'b0, 4'b1100, "lr_both");

        run_to_y(470, "to_bottom");
        chk("clamp.x", int'(bif.oBall_x), 630);
        cyc(1'b0, 1'b1, 1'b0, 4'b0001, "miss1");
        chk("miss1.state", int'(bif.oState), 2);
        chk("miss1.lives", int'(bif.oLives), 2);
        for (int i = 0; i < 60; i++) cyc(1'(i % 2), 1'b1, 1'b1, 4'b0000, "hold1");
        chk("reserve.state", int'(bif.oState), 0);

        for (int m = 2; m <= 3; m++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'b0000, "serve_m");
            cyc(1'b0, 1'b1, 1'b0, 4'b0010, "turn_down");
            run_to_y(470, "to_bottom_m");
            cyc(1'b0, 1'b1, 1'b0, 4'b0001, "miss_m");
            if (m == 2) for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1'b0, 4'b0000, "hold2");
        end
        chk("over.state", int'(bif.oState), 3);
        chk("over.lives", int'(bif.oLives), 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 4'b0000, "over_frozen");
        cyc(1'b1, 1'b1, 1'b0, 4'b0000, "restart");
        chk("restart.lives", int'(bif.oLives), 3);
        cyc(1'b0, 1'b1, 1'b0, 4'b0000, "restart_idle");

        d2(1'b1, 1'b1, 1'b0, 320, 240, "div2.serve");
        d2(1'b0, 1'b1, 1'b0, 320, 240, "div2.t1");
        d2(1'b0, 1'b1, 1'b0, 321, 239, "div2.t2");
        d2(1'b0, 1'b1, 1'b0, 321, 239, "div2.t3");
        for (int i = 0; i < 10; i++) d2(1'b0, 1'b1, 1'b1, 321, 239, "div2.pause");
        d2(1'b0, 1'b1, 1'b0, 322, 238, "div2.held");
        d2(1'b0, 1'b0, 1'b0, 322, 238, "div2.notick");
        d2(1'b0, 1'b1, 1'b0, 322, 238, "div2.t5");
        d2(1'b0, 1'b1, 1'b0, 323, 237, "div2.t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual=running expected=finished");
        $fatal(1);
    end
endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
Ball trajectory controller for the paddle game on the 640x480 screen. It sits directly downstream of the crash detector. It consumes the 4-bit crash vector {left,right,up,down} and steps the ball one pixel per axis on divided frame ticks. It reflects the ball's direction on crashes, detects a bottom-wall miss, and runs the serve/miss/game-over sequence. Its ball position outputs feed the crash detector and the VGA renderer.

Parameters:
X_INIT, 320, ball centre x at reset, serve and re-serve
Y_INIT, 240, ball centre y at reset, serve and re-serve
Y_MAX, 470, ball centre y at which a bottom crash counts as a miss
SPEED_DIV, 1, number of frame ticks per one-pixel step (1..15)
HOLD_FRAMES, 60, frame ticks the ball stays frozen after a miss (1..255)
LIVES, 3, lives loaded at reset and after game over (1..3)

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iFrame_tick  in  1  one-cycle pulse per video frame
iCrash  in  4  {left,right,up,down} from crash detector, combinational from current oBall_x/oBall_y
iStart  in  1  serve / restart request; level, sampled each cycle
iPause  in  1  freeze motion and divider while high
oBall_x  out  10  ball centre x
oBall_y  out  10  ball centre y
oDir  out  2  [1]=1 x increasing, [0]=1 y increasing
oLives  out  2  remaining lives
oState  out  2  IDLE=0, RUN=1, MISS=2, OVER=3
oBounce  out  1  one-cycle pulse when a step reverses any direction
oMiss  out  1  one-cycle pulse on entering MISS

Behaviour:
- One clock: iCLK. Reset is asynchronous and active-low on iRST_N. Assertion takes effect immediately, including mid-RUN or mid-MISS.
- Reset values: oBall_x=X_INIT, oBall_y=Y_INIT, oDir=2'b10 (right, up), oLives=LIVES, oState=IDLE, oBounce=0, oMiss=0, divider=0, hold counter=0.
- IDLE: ball is frozen. iStart=1 moves to RUN on the next edge and clears the divider.
- RUN: step_en = iFrame_tick & ~iPause & (div==SPEED_DIV-1).
  - On a tick with step_en=0 and iPause=0, div increments.
  - On a step, div goes to 0.
  - iPause=1 holds div and position.
- Step evaluation uses iCrash sampled in the step_en cycle. Miss check comes first.
- Miss: down=1 and oBall_y>=Y_MAX.
  - No motion; oLives decrements; oMiss pulses.
  - State goes to OVER if oLives was 1, otherwise MISS.
- X axis, when there is no miss:
  - left=1 only: dir_x=1.
  - right=1 only: dir_x=0.
  - Both set: dir_x unchanged and x not moved this step.
  - Neither set: dir_x unchanged.
  - Then x moves ±1 per the new dir_x.
- Y axis: same rules, with up setting dir_y=1 and down setting dir_y=0.
- Ordering within a step: direction updates before movement. For example, at x=10 moving left with left=1, the ball goes to x=11.
- oBounce pulses if either dir bit changed in that step.
- Position results are clamped to [10,630] for x and [10,470] for y. Arithmetic is unsigned 10-bit and never wraps.
- Latency: the position register updates on the edge after step_en. iCrash is valid for the new position one cycle later. Step spacing of at least 1 frame guarantees settled iCrash.
- MISS: the ball is frozen at the miss position. Count HOLD_FRAMES iFrame_ticks; iPause has no effect. Then:
  - x=X_INIT, y=Y_INIT, oDir=2'b10.
  - State goes to IDLE.
- OVER: the ball is frozen. iStart=1 causes:
  - oLives=LIVES, position=init, oDir=2'b10.
  - State goes to IDLE.
- iStart is ignored in RUN and MISS. In IDLE a held iStart serves once; re-serve needs a return to IDLE.
- iFrame_tick in the same cycle as a state-changing iStart is not counted.

Decomposition:
- Shared package game_pkg:
  - state encodings IDLE/RUN/MISS/OVER;
  - screen constants H_RES=640, V_RES=480, BALL_R=10, X_MIN=10, X_MAX=630, Y_MIN=10, Y_MAX default;
  - crash bit indices CRASH_LEFT=3, CRASH_RIGHT=2, CRASH_UP=1, CRASH_DOWN=0.
- One sub-module: tick_divider. It is the frame-tick counter with enable/clear, producing step_en. The MISS hold counter stays inline.

Test Plan:
- Reset and idle: iRST_N=0, then release and apply 10 ticks with iStart=0 -> x=320, y=240, oDir=10, oLives=3, oState=0, no motion.
- Free motion: iStart pulse, SPEED_DIV=1, iCrash=0, 5 ticks -> x=325, y=235, oDir=10, oBounce never high.
- Bounce: at y=11 moving up, apply iCrash=4'b0010 on the step tick -> oDir[0]=1, y=12, x+1, oBounce high exactly 1 cycle. Same check with iCrash=4'b1100 -> x unchanged, dir_x unchanged.
- Miss and re-serve: y=470, iCrash=4'b0001 on step -> oState=MISS, oMiss 1 cycle, oLives=2, position held. After 60 ticks -> IDLE, x=320, y=240, oDir=10.
- Game over: three misses -> oState=OVER, oLives=0. iStart -> IDLE, oLives=3.
- Pause, divider and reset: SPEED_DIV=2 -> one step per 2 ticks. iPause=1 for 10 ticks -> no change, div held. iRST_N low mid-RUN -> outputs return to reset values before the next iCLK edge.
